// File: rtl/alu_mds_queued.sv
// Multi-cycle RV32M multiply/divide/remainder and shift unit fed by a request FIFO.
// One operation executes at a time; its result is held on the outputs until out_clear.
module alu_mds_queued #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned QDEPTH     = 2,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_op,
  input  logic [XLEN-1:0]       in_arg0,
  input  logic [XLEN-1:0]       in_arg1,
  input  logic [REG_ADDR_W-1:0] in_rd,
  output logic                  in_error,
  output logic                  busy,
  output logic                  out_valid,
  output logic [XLEN-1:0]       out_res,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_error,
  input  logic                  out_clear
);
  localparam int unsigned SH_W  = $clog2(XLEN);
  localparam int unsigned CNT_W = $clog2(XLEN + 1);
  localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(QDEPTH + 1);

  localparam logic [3:0] OP_MUL    = 4'd0;
  localparam logic [3:0] OP_MULH   = 4'd1;
  localparam logic [3:0] OP_MULHSU = 4'd2;
  localparam logic [3:0] OP_MULHU  = 4'd3;
  localparam logic [3:0] OP_DIV    = 4'd4;
  localparam logic [3:0] OP_DIVU   = 4'd5;
  localparam logic [3:0] OP_REM    = 4'd6;
  localparam logic [3:0] OP_REMU   = 4'd7;
  localparam logic [3:0] OP_SLL    = 4'd8;
  localparam logic [3:0] OP_SRL    = 4'd9;
  localparam logic [3:0] OP_SRA    = 4'd10;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;

  logic [2:0] state, state_nx;

  // Request FIFO
  logic [3:0]            q_op [QDEPTH];
  logic [XLEN-1:0]       q_a  [QDEPTH];
  logic [XLEN-1:0]       q_b  [QDEPTH];
  logic [REG_ADDR_W-1:0] q_rd [QDEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [OCC_W-1:0]      occ;
  logic                  legal_op, push, pop, fifo_empty;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign legal_op   = (in_op <= OP_SRA);
  assign in_ready   = (occ != OCC_W'(QDEPTH));
  assign in_error   = in_valid & in_ready & ~legal_op;
  assign push       = in_valid & in_ready & legal_op;
  assign fifo_empty = (occ == '0);
  assign pop        = !fifo_empty && ((state == S_IDLE) || ((state == S_OUT) && out_clear));
  assign busy       = (state != S_IDLE) || !fifo_empty;

  always_ff @(posedge clk) begin
    if (push) begin
      q_op[wr_ptr] <= in_op;
      q_a[wr_ptr]  <= in_arg0;
      q_b[wr_ptr]  <= in_arg1;
      q_rd[wr_ptr] <= in_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Active entry and iteration datapath
  logic [3:0]            op_r;
  logic [XLEN-1:0]       arg0_r, arg1_r;
  logic [REG_ADDR_W-1:0] rd_r;
  logic [XLEN-1:0]       hi, lo, m;
  logic [CNT_W-1:0]      cnt;
  logic                  neg_res, neg_a;

  logic                  is_mul_r, is_div_r, sa_c, sb_c, div_zero_c, last_iter;
  logic [XLEN-1:0]       mag_a_c, mag_b_c, shifted, div_diff, quo, rmd, res_c;
  logic [SH_W-1:0]       shamt_c;
  logic [CNT_W-1:0]      step_c;
  logic [XLEN:0]         mul_sum, div_t;
  logic                  div_ge;
  logic [2*XLEN-1:0]     prod, prod_s;

  assign is_mul_r   = (op_r[3:2] == 2'b00);
  assign is_div_r   = (op_r[3:2] == 2'b01);
  assign sa_c       = arg0_r[XLEN-1] & (op_r inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
  assign sb_c       = arg1_r[XLEN-1] & (op_r inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
  assign mag_a_c    = sa_c ? -arg0_r : arg0_r;
  assign mag_b_c    = sb_c ? -arg1_r : arg1_r;
  assign shamt_c    = arg1_r[SH_W-1:0];
  assign div_zero_c = is_div_r && (arg1_r == '0);

  // Shifts move up to SHIFT_STEP bits per cycle, clipped on the last step
  always_comb begin
    step_c = CNT_W'(1);
    if (!is_mul_r && !is_div_r) begin
      step_c = (cnt >= CNT_W'(SHIFT_STEP)) ? CNT_W'(SHIFT_STEP) : cnt;
    end
  end
  assign last_iter = (cnt == step_c);

  always_comb begin
    shifted = hi;
    case (op_r)
      OP_SLL:  shifted = hi << step_c;
      OP_SRL:  shifted = hi >> step_c;
      OP_SRA:  shifted = $signed(hi) >>> step_c;
      default: shifted = hi;
    endcase
  end

  assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
  assign div_t    = {hi, lo[XLEN-1]};
  assign div_ge   = (div_t >= {1'b0, m});
  assign div_diff = XLEN'(div_t - {1'b0, m});

  assign prod   = {hi, lo};
  assign prod_s = neg_res ? -prod : prod;
  assign quo    = neg_res ? -lo : lo;
  assign rmd    = neg_a ? -hi : hi;

  always_comb begin
    res_c = hi;
    case (op_r)
      OP_MUL:                       res_c = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res_c = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              res_c = div_zero_c ? '1 : quo;
      OP_REM, OP_REMU:              res_c = div_zero_c ? arg0_r : rmd;
      default:                      res_c = hi;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (!fifo_empty) state_nx = S_LOAD;
      S_LOAD: begin
        if (div_zero_c || (!is_mul_r && !is_div_r && (shamt_c == '0))) state_nx = S_DONE;
        else                                                             state_nx = S_RUN;
      end
      S_RUN:  if (last_iter) state_nx = S_DONE;
      S_DONE: state_nx = S_OUT;
      S_OUT:  if (out_clear) state_nx = fifo_empty ? S_IDLE : S_LOAD;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_r      <= '0;
      arg0_r    <= '0;
      arg1_r    <= '0;
      rd_r      <= '0;
      hi        <= '0;
      lo        <= '0;
      m         <= '0;
      cnt       <= '0;
      neg_res   <= 1'b0;
      neg_a     <= 1'b0;
      out_valid <= 1'b0;
      out_res   <= '0;
      out_rd    <= '0;
      out_error <= 1'b0;
    end else begin
      if (pop) begin
        op_r   <= q_op[rd_ptr];
        arg0_r <= q_a[rd_ptr];
        arg1_r <= q_b[rd_ptr];
        rd_r   <= q_rd[rd_ptr];
      end
      case (state)
        S_LOAD: begin
          neg_res <= sa_c ^ sb_c;
          neg_a   <= sa_c;
          if (is_mul_r) begin
            hi  <= '0;
            lo  <= mag_b_c;
            m   <= mag_a_c;
            cnt <= CNT_W'(XLEN);
          end else if (is_div_r) begin
            hi  <= '0;
            lo  <= mag_a_c;
            m   <= mag_b_c;
            cnt <= CNT_W'(XLEN);
          end else begin
            hi  <= arg0_r;
            lo  <= '0;
            m   <= '0;
            cnt <= CNT_W'(shamt_c);
          end
        end
        S_RUN: begin
          cnt <= cnt - step_c;
          if (is_mul_r) begin
            hi <= mul_sum[XLEN:1];
            lo <= {mul_sum[0], lo[XLEN-1:1]};
          end else if (is_div_r) begin
            hi <= div_ge ? div_diff : div_t[XLEN-1:0];
            lo <= {lo[XLEN-2:0], div_ge};
          end else begin
            hi <= shifted;
          end
        end
        S_DONE: begin
          out_valid <= 1'b1;
          out_res   <= res_c;
          out_rd    <= rd_r;
          out_error <= div_zero_c;
        end
        S_OUT: begin
          if (out_clear) begin
            out_valid <= 1'b0;
            out_res   <= '0;
            out_rd    <= '0;
            out_error <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mds_queued.sv
// Bench for alu_mds_queued: directed edge cases plus random traffic against a
// transaction-level model (arithmetic reference results + latency formula).
module tb_alu_mds_queued;
  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned QD   = 2;
  localparam int unsigned STEP = 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic [3:0]      in_op = '0;
  logic [31:0]     in_arg0 = '0, in_arg1 = '0;
  logic [RW-1:0]   in_rd = '0;
  logic            out_clear = 1'b0;
  logic            in_ready, in_error, busy, out_valid, out_error;
  logic [31:0]     out_res;
  logic [RW-1:0]   out_rd;

  logic            d4_valid = 1'b0;
  logic [3:0]      d4_op = '0;
  logic [31:0]     d4_a = '0, d4_b = '0;
  logic [RW-1:0]   d4_rd = '0;
  logic            d4_clear = 1'b0;
  logic            d4_ready, d4_error, d4_busy, d4_ovalid, d4_oerr;
  logic [31:0]     d4_res;
  logic [RW-1:0]   d4_ord;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_mds_queued #(.XLEN(XLEN), .REG_ADDR_W(RW), .QDEPTH(QD), .SHIFT_STEP(STEP)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_arg0(in_arg0), .in_arg1(in_arg1), .in_rd(in_rd), .in_error(in_error), .busy(busy),
    .out_valid(out_valid), .out_res(out_res), .out_rd(out_rd), .out_error(out_error),
    .out_clear(out_clear));

  alu_mds_queued #(.XLEN(XLEN), .REG_ADDR_W(RW), .QDEPTH(QD), .SHIFT_STEP(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(d4_valid), .in_ready(d4_ready), .in_op(d4_op),
    .in_arg0(d4_a), .in_arg1(d4_b), .in_rd(d4_rd), .in_error(d4_error), .busy(d4_busy),
    .out_valid(d4_ovalid), .out_res(d4_res), .out_rd(d4_ord), .out_error(d4_oerr),
    .out_clear(d4_clear));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the RISC-V rules
  function automatic logic [32:0] ref_calc(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] p;
    logic [31:0] r;
    logic e;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    e = 1'b0;
    r = '0;
    p = '0;
    case (op)
      4'd0: begin p = sa * sb; r = p[31:0]; end
      4'd1: begin p = sa * sb; r = p[63:32]; end
      4'd2: begin p = sa * $signed({32'b0, b}); r = p[63:32]; end
      4'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      4'd4: begin
        if (b == 0) begin r = '1; e = 1'b1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else r = $signed(a) / $signed(b);
      end
      4'd5: begin if (b == 0) begin r = '1; e = 1'b1; end else r = a / b; end
      4'd6: begin
        if (b == 0) begin r = a; e = 1'b1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
        else r = $signed(a) % $signed(b);
      end
      4'd7: begin if (b == 0) begin r = a; e = 1'b1; end else r = a % b; end
      4'd8:  r = a << b[4:0];
      4'd9:  r = a >> b[4:0];
      4'd10: r = $signed(a) >>> b[4:0];
      default: r = '0;
    endcase
    return {e, r};
  endfunction

  function automatic int latency(input logic [3:0] op, input logic [31:0] b, input int step);
    if (op <= 4'd7) return (op >= 4'd4 && b == 0) ? 3 : XLEN + 3;
    return (int'(b[4:0]) + step - 1) / step + 3;
  endfunction

  typedef struct {
    logic [RW-1:0] rd;
    logic [31:0]   res;
    logic          err;
    int            lat;
  } req_t;

  // Transaction model: queue of accepted requests, one active job with a cycle timer
  req_t mq[$];
  req_t cur;
  int   m_st = 0;   // 0 idle, 1 computing, 2 result held
  int   timer = 0;
  int   sz;
  bit   clear_taken, do_pop;
  logic [32:0] rc;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_st = 0;
      timer = 0;
    end else begin
      sz = mq.size();
      clear_taken = (m_st == 2) && out_clear;
      do_pop = (sz > 0) && ((m_st == 0) || clear_taken);
      if (clear_taken) m_st = 0;
      if (m_st == 1) begin
        timer--;
        if (timer == 0) m_st = 2;
      end
      if (do_pop) begin
        cur = mq.pop_front();
        timer = cur.lat - 1;
        m_st = 1;
      end
      if (in_valid && sz < QD && in_op <= 4'd10) begin
        req_t t;
        rc = ref_calc(in_op, in_arg0, in_arg1);
        t.rd = in_rd;
        t.res = rc[31:0];
        t.err = rc[32];
        t.lat = latency(in_op, in_arg1, STEP);
        mq.push_back(t);
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(mq.size() < QD));
    chk("in_error", 32'(in_error), 32'(in_valid && (mq.size() < QD) && (in_op > 4'd10)));
    chk("busy", 32'(busy), 32'((m_st != 0) || (mq.size() > 0)));
    chk("out_valid", 32'(out_valid), 32'(m_st == 2));
    chk("out_res", out_res, (m_st == 2) ? cur.res : 32'h0);
    chk("out_rd", 32'(out_rd), (m_st == 2) ? 32'(cur.rd) : 32'h0);
    chk("out_error", 32'(out_error), (m_st == 2) ? 32'(cur.err) : 32'h0);
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [RW-1:0] rd);
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = op; in_arg0 = a; in_arg1 = b; in_rd = rd;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (1) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (out_valid) break;
      if (n > 300) begin
        checks++; errors++;
        $display("FAIL wait_valid: no out_valid after %0d cycles", n);
        break;
      end
    end
  endtask

  task automatic do_clear();
    @(posedge clk); #1 out_clear = 1'b1;
    @(posedge clk); #1 out_clear = 1'b0;
  endtask

  task automatic directed(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input logic exp_err, input int exp_lat);
    int n;
    issue(op, a, b, 5'd7);
    wait_valid(n);
    chk({name, "_res"}, out_res, exp_res);
    chk({name, "_err"}, 32'(out_error), 32'(exp_err));
    chk({name, "_rd"}, 32'(out_rd), 32'd7);
    if (exp_lat > 0) chk({name, "_lat"}, n, exp_lat);
    do_clear();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 40);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n, seen;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);

    directed("mul_neg", 4'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 1'b0, 35);
    directed("mulhu", 4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 35);
    directed("mulhsu", 4'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0, 35);
    directed("div_by0", 4'd4, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b1, 3);
    directed("remu_by0", 4'd7, 32'd7, 32'd0, 32'd7, 1'b1, 3);
    directed("div_ovf", 4'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 35);
    directed("rem_ovf", 4'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 35);
    directed("rem_neg", 4'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 35);
    directed("div_neg", 4'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 35);
    directed("sra4", 4'd10, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 7);
    directed("sll0", 4'd8, 32'h1234_5678, 32'd0, 32'h1234_5678, 1'b0, 3);

    // Three DIVUs back to back while the first runs
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = 4'd5; in_arg0 = 32'd100; in_arg1 = 32'd7; in_rd = 5'd1;
    @(posedge clk); #1;
    in_arg0 = 32'd200; in_arg1 = 32'd9; in_rd = 5'd2;
    @(posedge clk); #1;
    in_arg0 = 32'd300; in_arg1 = 32'd11; in_rd = 5'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("q_full_ready", 32'(in_ready), 32'd0);
    wait_valid(n);
    chk("q_res0", out_res, 32'd14);
    chk("q_rd0", 32'(out_rd), 32'd1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_res !== 32'd14 || out_valid !== 1'b1) chk("q_hold", out_res, 32'd14);
    end
    chk("q_hold_end", out_res, 32'd14);
    do_clear();
    wait_valid(n);
    chk("q_gap", n, 34);
    chk("q_res1", out_res, 32'd22);
    chk("q_rd1", 32'(out_rd), 32'd2);
    do_clear();
    wait_valid(n);
    chk("q_res2", out_res, 32'd27);
    chk("q_rd2", 32'(out_rd), 32'd3);
    do_clear();

    // Illegal opcode is consumed without a result
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = 4'd12;
    @(negedge clk);
    chk("illegal_err", 32'(in_error), 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || out_valid) seen++;
    end
    chk("illegal_quiet", seen, 0);

    // Reset in the middle of a MUL with a second one queued
    issue(4'd0, 32'd3, 32'd5, 5'd4);
    issue(4'd1, 32'd3, 32'd5, 5'd6);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_res", out_res, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rst_no_result", seen, 0);

    // Random traffic, checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 999) == 0);
      in_valid = ($urandom_range(0, 3) == 0);
      in_op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
      in_arg0 = pick();
      in_arg1 = pick();
      in_rd = 5'($urandom);
      out_clear = ($urandom_range(0, 3) == 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_clear = 1'b1;
    repeat (200) @(posedge clk);
    #1 out_clear = 1'b0;

    // Four-bit shift step with a clipped final step
    @(posedge clk); #1;
    d4_valid = 1'b1; d4_op = 4'd9; d4_a = 32'hFFFF_FFFF; d4_b = 32'd31;
    @(posedge clk); #1 d4_valid = 1'b0;
    n = 0;
    while (1) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (d4_ovalid || n > 100) break;
    end
    chk("s4_srl_lat", n, 11);
    chk("s4_srl_res", d4_res, 32'h0000_0001);
    @(posedge clk); #1 d4_clear = 1'b1;
    @(posedge clk); #1 d4_clear = 1'b0;
    @(posedge clk); #1;
    d4_valid = 1'b1; d4_op = 4'd10; d4_a = 32'h8000_0000; d4_b = 32'd5;
    @(posedge clk); #1 d4_valid = 1'b0;
    n = 0;
    while (1) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (d4_ovalid || n > 100) break;
    end
    chk("s4_sra_lat", n, 5);
    chk("s4_sra_res", d4_res, 32'hFC00_0000);
    @(posedge clk); #1 d4_clear = 1'b1;
    @(posedge clk); #1 d4_clear = 1'b0;
    @(negedge clk);
    chk("s4_cleared", 32'(d4_ovalid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
